// File: rtl/sample_loader_if.sv
// Stream-in / frame-out bundle between the upstream source, the sample loader
// and the averaging datapath. The loader uses the slave modport.
interface sample_loader_if #(
  parameter int N = 32,
  parameter int W = 8
);
  localparam int LOGN = $clog2(N);

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             consume_done;
  logic [W-1:0]     frame_out [0:N-1];
  logic             start;
  logic             busy;
  logic [LOGN:0]    wr_count;
  logic [7:0]       frame_count;
  logic [W+LOGN-1:0] sum_out;

  modport master (
    output in_valid, in_data, consume_done,
    input  in_ready, frame_out, start, busy, wr_count, frame_count, sum_out
  );

  modport slave (
    input  in_valid, in_data, consume_done,
    output in_ready, frame_out, start, busy, wr_count, frame_count, sum_out
  );
endinterface

// File: rtl/sample_loader.sv
// Collects N stream samples into a frozen frame buffer, pulses start, then waits
// for the datapath to finish. Optional running sum enabled by LOADER_SUM_EN.
module sample_loader #(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic             clk,
  input logic             reset,
  sample_loader_if.slave  bus
);
  localparam int LOGN = $clog2(N);

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [LOGN-1:0] r_wr_idx;
  logic [LOGN:0]   r_wr_count;
  logic [7:0]      r_frame_count;
  logic [W-1:0]    r_buf [0:N-1];

  logic w_xfer;
  logic w_last;
  logic w_consume;
  logic w_start;
  logic w_busy;
  logic w_in_ready;

  assign w_xfer    = bus.in_valid && (r_state == S_FILL);
  assign w_last    = w_xfer && (r_wr_idx == LOGN'(N - 1));
  // consume_done is only honoured in WAIT; in LAUNCH it still reflects the last frame
  assign w_consume = (r_state == S_WAIT) && bus.consume_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_busy       = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      S_FILL: begin
        w_in_ready = 1'b1;
        if (w_last) w_state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        w_start      = 1'b1;
        w_busy       = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (w_consume) w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  // Write index wraps to 0 on its own after N-1 since N is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx      <= '0;
      r_wr_count    <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_xfer) begin
        r_wr_idx   <= r_wr_idx + 1'b1;
        r_wr_count <= r_wr_count + 1'b1;
      end
      if (w_consume) begin
        r_wr_count    <= '0;
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (reset) begin
          r_buf[gi] <= '0;
        end else if (w_xfer && (r_wr_idx == LOGN'(gi))) begin
          r_buf[gi] <= bus.in_data;
        end
      end
      assign bus.frame_out[gi] = r_buf[gi];
    end
  endgenerate

`ifdef LOADER_SUM_EN
  logic [W+LOGN-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_consume) begin
      r_sum <= '0;
    end else if (w_xfer) begin
      r_sum <= r_sum + (W + LOGN)'(bus.in_data);
    end
  end

  assign bus.sum_out = r_sum;
`else
  assign bus.sum_out = '0;
`endif

  assign bus.in_ready    = w_in_ready;
  assign bus.start       = w_start;
  assign bus.busy        = w_busy;
  assign bus.wr_count    = r_wr_count;
  assign bus.frame_count = r_frame_count;
endmodule

// File: doc/sample_loader.md
Name: sample_loader

Overview:
- Upstream stage of the averaging datapath.
- Accepts bytes one per cycle over a valid/ready stream and assembles a frame of N samples in an internal buffer.
- Presents the frame as an unpacked array to the mean datapath's sample input, issues a one-cycle start pulse, then holds the buffer frozen until the datapath signals completion.
- Refills for the next frame once completion is signalled.

Parameters:
- N, 32, samples per frame; power of two, ≥2.
- W, 8, sample width in bits.
- LOGN, $clog2(N), write-index width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream sample valid.
- in_data  input  W  upstream sample.
- in_ready  output  1  loader can accept a sample this cycle.
- consume_done  input  1  level from the downstream datapath's count-complete flag; frame fully consumed.
- frame_out  output  W x N  unpacked array [0:N-1] driven from the buffer; feeds the datapath sample input.
- start  output  1  one-cycle pulse: frame valid, begin accumulation.
- busy  output  1  high in LAUNCH and WAIT.
- wr_count  output  LOGN+1  samples accepted in the current frame (0..N).
- frame_count  output  8  completed frames handed off; wraps 255→0.
- sum_out  output  W+LOGN  running sum of the current frame (see Optional Feature).

Behaviour:
- Reset (sync, active-high): state=FILL; wr_idx=0; wr_count=0; frame_count=0; every buffer entry=0; start=0; busy=0; sum_out=0; in_ready=1 in the cycle after reset is released. Reset asserted in any state aborts the frame immediately; no start pulse is emitted.
- Handshake: a sample transfers when in_valid && in_ready at the rising edge. in_ready is a registered-state decode (in_ready=1 iff state==FILL) with no combinational path from in_valid.
- FILL:
  - On transfer: buf[wr_idx]<=in_data; wr_idx<=wr_idx+1; wr_count<=wr_count+1.
  - If the transfer has wr_idx==N-1: wr_idx wraps to 0; wr_count=N; next state=LAUNCH.
  - No transfer: hold.
- LAUNCH (exactly 1 cycle): start=1; in_ready=0; busy=1; next state=WAIT. consume_done is ignored in this cycle, because the datapath's flag is stale from the previous frame.
- WAIT:
  - in_ready=0; busy=1; buffer frozen, so frame_out is stable for the entire accumulation.
  - On consume_done=1: frame_count<=frame_count+1; wr_count<=0; sum_out<=0; next state=FILL.
  - in_valid is ignored; data is not lost because in_ready=0.
- Latency: the start pulse comes 1 cycle after the Nth accepted sample. in_ready reasserts 1 cycle after consume_done is sampled high.
- Buffer contents persist across frames and are overwritten in place. They are never cleared except by reset.
- frame_out[i] is the buf[i] register output directly, with no extra combinational logic.

Optional Feature:
- Macro LOADER_SUM_EN.
- Defined:
  - sum_out accumulates the zero-extended sum of accepted samples in the current frame, W+LOGN bits (13 bits at defaults), no overflow possible.
  - Updates on each transfer and holds through LAUNCH/WAIT.
  - After the frame, sum_out equals the datapath accumulator's final value, for cross-checking its mean (mean = sum_out >> LOGN).
- Undefined: sum_out tied to 0, with no accumulator logic.

Test Plan:
- Reset then stream 32 samples of value k (k=0..31), in_valid held high -> in_ready high for 32 cycles; start pulses once, 1 cycle after the last sample; frame_out[i]=i; busy=1; wr_count=32; with LOADER_SUM_EN, sum_out=496.
- In WAIT, drive in_valid=1 with in_data=8'hFF for 10 cycles -> in_ready=0 throughout; frame_out unchanged; wr_count stays 32.
- Assert consume_done during the LAUNCH cycle only -> ignored; state remains WAIT. Assert it 5 cycles later -> frame_count=1; in_ready=1 next cycle; wr_count=0.
- Second frame with all samples 8'hFF, gaps in in_valid every other cycle -> start is delayed until the 32nd transfer; frame_out all 8'hFF; sum_out=13'd8160 (feature on); frame_count increments to 2 on the next consume_done.
- Assert reset after 17 samples -> next cycle: wr_count=0; all frame_out=0; no start pulse; in_ready=1.
- Run 256 frames -> frame_count wraps to 0.
